// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: MIPS control codes, slice op encodings,
// controller states and decoded-control structs. ALU_SERIAL_OVF_EN adds the overflow-op flag.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_PASSA = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    SLICE_AND  = 2'b00,
    SLICE_OR   = 2'b01,
    SLICE_ADD  = 2'b10,
    SLICE_LESS = 2'b11
  } slice_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic      invert_a;
    logic      invert_b;
    logic      null_add;
    slice_op_e alu_op;
  } slice_ctrl_t;

  typedef struct packed {
    slice_ctrl_t slice;
    logic        cin;
    logic        post_inv;
    logic        is_slt;
`ifdef ALU_SERIAL_OVF_EN
    logic        ovf_op;
`endif
    logic        illegal;
  } ctrl_t;

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/response bundle of the bit-serial ALU. ALU_SERIAL_OVF_EN adds ovf_o.
interface alu_serial_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [3:0]       op_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             cout_o;
  logic             busy_o;
`ifdef ALU_SERIAL_OVF_EN
  logic             ovf_o;
`endif

  modport slave (
    input  in_valid_i, op_i, src1_i, src2_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, zero_o, cout_o, busy_o
`ifdef ALU_SERIAL_OVF_EN
    , output ovf_o
`endif
  );

  modport master (
    output in_valid_i, op_i, src1_i, src2_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, zero_o, cout_o, busy_o
`ifdef ALU_SERIAL_OVF_EN
    , input ovf_o
`endif
  );
endinterface

// File: rtl/ALU_1bit.sv
// One-bit ALU slice: AND/OR on raw inputs, full adder on optionally inverted/nulled inputs.
module ALU_1bit
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       carryIn,
  input  logic       invertA,
  input  logic       invertB,
  input  logic       nullAdd,
  input  logic       less,
  input  logic [1:0] aluOp,
  output logic       result,
  output logic       carryOut
);
  logic a_m, b_m, sum;

  assign a_m      = a ^ invertA;
  assign b_m      = nullAdd ? 1'b0 : (b ^ invertB);
  assign sum      = a_m ^ b_m ^ carryIn;
  assign carryOut = (a_m & b_m) | (a_m & carryIn) | (b_m & carryIn);

  always_comb begin
    // NOTE: assign every always_comb output a default first so no path infers a latch.
    result = 1'b0;
    case (aluOp)
      SLICE_AND:  result = a & b;
      SLICE_OR:   result = a | b;
      SLICE_ADD:  result = sum;
      SLICE_LESS: result = less;
      default:    result = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_serial_decode.sv
// Maps the 4-bit MIPS ALU control code to slice controls, carry-init, post-invert and
// illegal flag. ALU_SERIAL_OVF_EN marks the ops that report signed overflow.
module alu_serial_decode
  import alu_pkg::*;
(
  input  logic [3:0] op,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl              = '0;
    ctrl.slice.alu_op = SLICE_AND;
    case (op)
      ALU_AND: ctrl.slice.alu_op = SLICE_AND;
      ALU_OR:  ctrl.slice.alu_op = SLICE_OR;
      ALU_ADD: begin
        ctrl.slice.alu_op = SLICE_ADD;
`ifdef ALU_SERIAL_OVF_EN
        ctrl.ovf_op = 1'b1;
`endif
      end
      ALU_SUB, ALU_SLT: begin
        ctrl.slice.invert_b = 1'b1;
        ctrl.slice.alu_op   = SLICE_ADD;
        ctrl.cin            = 1'b1;
        ctrl.is_slt         = (op == ALU_SLT);
`ifdef ALU_SERIAL_OVF_EN
        ctrl.ovf_op = 1'b1;
`endif
      end
      // The slice's OR path ignores invert controls, so NOR inverts the OR bit afterwards.
      ALU_NOR: begin
        ctrl.slice.alu_op = SLICE_OR;
        ctrl.post_inv     = 1'b1;
      end
      ALU_PASSA: begin
        ctrl.slice.null_add = 1'b1;
        ctrl.slice.alu_op   = SLICE_ADD;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one ALU_1bit slice, LSB first, one bit per clock, with a
// valid/ready result handshake. ALU_SERIAL_OVF_EN adds ovf_o and overflow-corrected SLT.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input logic              clk_i,
  input logic              rst_i,
  alu_serial_ctrl_if.slave bus
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res_sr;
  ctrl_t            ctrl_d;
  slice_ctrl_t      slice_q;
  logic             post_inv_q, is_slt_q, illegal_q;
  logic             carry_q, nz_acc;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, cout_q;
  logic             slice_res, slice_cout, res_bit, accept, last, slt_set;
  logic [WIDTH-1:0] full_res, fin_result;
  logic             fin_zero, fin_cout;
`ifdef ALU_SERIAL_OVF_EN
  logic             ovf_op_q, ovf_q, ovf, fin_ovf;
`endif

  alu_serial_decode u_decode (.op(bus.op_i), .ctrl(ctrl_d));

  ALU_1bit u_slice (
    .a(a_sr[0]), .b(b_sr[0]), .carryIn(carry_q),
    .invertA(slice_q.invert_a), .invertB(slice_q.invert_b), .nullAdd(slice_q.null_add),
    .less(1'b0), .aluOp(slice_q.alu_op),
    .result(slice_res), .carryOut(slice_cout)
  );

  assign res_bit = slice_res ^ post_inv_q;
  assign accept  = (state_q == IDLE) && bus.in_valid_i;
  assign last    = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

  // On the last RUN cycle carry_q is the carry into the MSB and slice_cout the carry out.
  always_comb begin
    full_res   = {res_bit, res_sr};
    fin_result = full_res;
    fin_zero   = ~(nz_acc | res_bit);
    fin_cout   = (slice_q.alu_op == SLICE_ADD) & slice_cout;
`ifdef ALU_SERIAL_OVF_EN
    ovf        = carry_q ^ slice_cout;
    fin_ovf    = ovf_op_q & ovf;
    slt_set    = res_bit ^ ovf;
`else
    slt_set    = res_bit;
`endif
    if (is_slt_q) begin
      fin_result = {{(WIDTH-1){1'b0}}, slt_set};
      fin_zero   = ~slt_set;
    end
    if (illegal_q) begin
      fin_result = '0;
      fin_zero   = 1'b1;
      fin_cout   = 1'b0;
`ifdef ALU_SERIAL_OVF_EN
      fin_ovf    = 1'b0;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid_i) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (bus.out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q      <= '0;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      slice_q    <= '0;
      post_inv_q <= 1'b0;
      is_slt_q   <= 1'b0;
      illegal_q  <= 1'b0;
      carry_q    <= 1'b0;
      nz_acc     <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      cout_q     <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
      ovf_op_q   <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else if (accept) begin
      a_sr       <= bus.src1_i;
      b_sr       <= bus.src2_i;
      slice_q    <= ctrl_d.slice;
      post_inv_q <= ctrl_d.post_inv;
      is_slt_q   <= ctrl_d.is_slt;
      illegal_q  <= ctrl_d.illegal;
      carry_q    <= ctrl_d.cin;
      cnt_q      <= '0;
      nz_acc     <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
      ovf_op_q   <= ctrl_d.ovf_op;
`endif
    end else if (state_q == RUN) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      res_sr  <= full_res[WIDTH-1:1];
      carry_q <= slice_cout;
      nz_acc  <= nz_acc | res_bit;
      if (last) begin
        result_q <= fin_result;
        zero_q   <= fin_zero;
        cout_q   <= fin_cout;
`ifdef ALU_SERIAL_OVF_EN
        ovf_q    <= fin_ovf;
`endif
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_ready_o  = (state_q == IDLE);
  assign bus.out_valid_o = (state_q == DONE);
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.result_o    = result_q;
  assign bus.zero_o      = zero_q;
  assign bus.cout_o      = cout_q;
`ifdef ALU_SERIAL_OVF_EN
  assign bus.ovf_o       = ovf_q;
`endif
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl (WIDTH=32); ovf_o checked only with ALU_SERIAL_OVF_EN.
module tb_alu_serial_ctrl;
  import alu_pkg::*;

  localparam int WIDTH = 32;
`ifdef ALU_SERIAL_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_serial_ctrl_if #(.WIDTH(WIDTH)) bus ();

  alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge right after the accept edge.
  task automatic start_op(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.op_i       = op;
    bus.src1_i     = a;
    bus.src2_i     = b;
    bus.in_valid_i = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  // Counts clock edges from the accept edge until out_valid_o is seen, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic finish_op(input string tag);
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    check({tag, "_vld_drop"}, bus.out_valid_o, 1'b0);
  endtask

  task automatic do_op(input string tag, input logic [3:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] exp_res, input logic exp_zero,
                       input logic exp_cout, input logic exp_ovf);
    int n;
    start_op(op, a, b);
    wait_valid(n);
    check({tag, "_lat"}, n, WIDTH);
    check({tag, "_res"}, bus.result_o, exp_res);
    check({tag, "_zero"}, bus.zero_o, exp_zero);
    check({tag, "_cout"}, bus.cout_o, exp_cout);
`ifdef ALU_SERIAL_OVF_EN
    check({tag, "_ovf"}, bus.ovf_o, exp_ovf);
`else
    if (exp_ovf === 1'bx) check({tag, "_ovf_arg"}, 1'b0, 1'b1);
`endif
    finish_op(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.op_i        = 4'h0;
    bus.src1_i      = '0;
    bus.src2_i      = '0;

    repeat (3) @(negedge clk);
    check("rst_res", bus.result_o, '0);
    check("rst_zero", bus.zero_o, 1'b0);
    check("rst_cout", bus.cout_o, 1'b0);
    check("rst_vld", bus.out_valid_o, 1'b0);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_rdy", bus.in_ready_o, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("add_ovf", ALU_ADD,   32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    do_op("sub_eq",  ALU_SUB,   32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    do_op("sub_neg", ALU_SUB,   32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    do_op("slt_m1",  ALU_SLT,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    do_op("slt_ovf", ALU_SLT,   32'h8000_0000, 32'h0000_0001,
          OVF_EN ? 32'h0000_0001 : 32'h0000_0000, !OVF_EN, 1'b1, 1'b1);
    do_op("nor",     ALU_NOR,   32'h0F0F_0000, 32'h00F0_000F, 32'hF000_FFF0, 1'b0, 1'b0, 1'b0);
    do_op("and",     ALU_AND,   32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0, 1'b0);
    do_op("or",      ALU_OR,    32'hA0A0_A0A0, 32'h0505_0505, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0);
    do_op("passa",   ALU_PASSA, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    do_op("illegal", 4'b1111,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0);

    // Backpressure: in_valid_i held high, new operands presented while busy.
    bus.op_i       = ALU_ADD;
    bus.src1_i     = 32'd1;
    bus.src2_i     = 32'd1;
    bus.in_valid_i = 1'b1;
    @(negedge clk);
    bus.src1_i = 32'd10;
    bus.src2_i = 32'd20;
    wait_valid(n);
    check("bp_lat", n, WIDTH);
    for (int i = 0; i < 5; i++) begin
      check("bp_vld", bus.out_valid_o, 1'b1);
      check("bp_res", bus.result_o, 32'd2);
      check("bp_rdy", bus.in_ready_o, 1'b0);
      @(negedge clk);
    end
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    check("bp_idle_rdy", bus.in_ready_o, 1'b1);
    check("bp_idle_vld", bus.out_valid_o, 1'b0);
    check("bp_idle_busy", bus.busy_o, 1'b0);
    check("bp_hold_res", bus.result_o, 32'd2);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    check("bp_acc2_busy", bus.busy_o, 1'b1);
    check("bp_acc2_rdy", bus.in_ready_o, 1'b0);
    wait_valid(n);
    check("bp2_lat", n, WIDTH);
    check("bp2_res", bus.result_o, 32'd30);
    finish_op("bp2");

    // Nonzero outputs beforehand, then reset at counter=10 mid-RUN.
    do_op("slt_pre", ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    start_op(ALU_ADD, 32'h0000_FFFF, 32'h0000_0001);
    repeat (10) @(negedge clk);
    check("mid_busy", bus.busy_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mr_res", bus.result_o, '0);
    check("mr_zero", bus.zero_o, 1'b0);
    check("mr_cout", bus.cout_o, 1'b0);
    check("mr_vld", bus.out_valid_o, 1'b0);
    check("mr_busy", bus.busy_o, 1'b0);
`ifdef ALU_SERIAL_OVF_EN
    check("mr_ovf", bus.ovf_o, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_vld", bus.out_valid_o, 1'b0);
    do_op("add_after_rst", ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
